// File: rtl/dp_ram_pkg.sv
// rtl/dp_ram_pkg.sv - shared types and helpers for dp_ram_clr
//   clr_state_t : clear-engine states
//   be_w()      : byte-enable width for a given word width
//   merge_bytes : replace enabled bytes of a word (write path and bypass path)
package dp_ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } clr_state_t;

  // merge_bytes works on a wide container so one function serves every
  // DATA_WIDTH; callers zero-extend into it and truncate the result.
  localparam int MAX_DW = 1024;
  localparam int MAX_BE = MAX_DW / 8;

  typedef logic [MAX_DW-1:0] word_max_t;
  typedef logic [MAX_BE-1:0] be_max_t;

  function automatic int be_w(input int data_width);
    return data_width / 8;
  endfunction

  function automatic word_max_t merge_bytes(input word_max_t old_word,
                                            input word_max_t new_word,
                                            input be_max_t   be);
    word_max_t res;
    res = old_word;
    for (int i = 0; i < MAX_BE; i++) begin
      if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dp_ram_clr_fsm.sv
// rtl/dp_ram_clr_fsm.sv - clear engine and write-port mux for dp_ram_clr
//   wr_clk, reset           : clock, async active-high reset
//   clr_req                 : request a fresh sweep (honoured in IDLE only)
//   wr_en/wr_be/write_*     : user write port
//   busy                    : registered (state == CLEAR)
//   mem_we/mem_addr/...     : write port into the array (clear or user)
module dp_ram_clr_fsm
  import dp_ram_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] CLR_VALUE  = '0
) (
  input  logic                      wr_clk,
  input  logic                      reset,
  input  logic                      clr_req,
  input  logic                      wr_en,
  input  logic [DATA_WIDTH/8-1:0]   wr_be,
  input  logic [ADDR_WIDTH-1:0]     write_addr,
  input  logic [DATA_WIDTH-1:0]     write_data,
  output logic                      busy,
  output logic                      mem_we,
  output logic [ADDR_WIDTH-1:0]     mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  output logic [DATA_WIDTH/8-1:0]   mem_be
);

  clr_state_t            state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
  logic                  busy_q, busy_d;

  always_ff @(posedge wr_clk or posedge reset) begin
    if (reset) begin
      state_q    <= CLEAR;
      clr_addr_q <= '0;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    case (state_q)
      CLEAR: begin
        clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
        // Last address is all-ones since DEPTH is a power of two.
        if (clr_addr_q == '1) state_d = IDLE;
      end
      IDLE: begin
        if (clr_req) begin
          state_d    = CLEAR;
          clr_addr_d = '0;
        end
      end
      default: state_d = CLEAR;
    endcase
    // Tracking state_d keeps busy_q identical to (state_q == CLEAR).
    busy_d = (state_d == CLEAR);
  end

  assign busy = busy_q;

  always_comb begin
    mem_we    = wr_en;
    mem_addr  = write_addr;
    mem_wdata = write_data;
    mem_be    = wr_be;
    if (state_q == CLEAR) begin
      mem_we    = 1'b1;
      mem_addr  = clr_addr_q;
      mem_wdata = CLR_VALUE;
      mem_be    = '1;
    end
  end

endmodule

// File: rtl/dp_ram_clr.sv
// rtl/dp_ram_clr.sv - simple dual-port RAM with byte enables and clear engine
//   wr_clk, reset              : clock, async active-high reset
//   clr_req, busy              : re-clear request, clear-in-progress flag
//   wr_en, wr_be, write_addr, write_data : write port
//   rd_en, read_addr           : read port request
//   read_data, rd_valid        : registered read data and its one-cycle qualifier
module dp_ram_clr
  import dp_ram_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    BYPASS     = 1,
  parameter logic [DATA_WIDTH-1:0] CLR_VALUE  = '0
) (
  input  logic                      wr_clk,
  input  logic                      reset,
  input  logic                      clr_req,
  output logic                      busy,
  input  logic                      wr_en,
  input  logic [DATA_WIDTH/8-1:0]   wr_be,
  input  logic [ADDR_WIDTH-1:0]     write_addr,
  input  logic [DATA_WIDTH-1:0]     write_data,
  input  logic                      rd_en,
  input  logic [ADDR_WIDTH-1:0]     read_addr,
  output logic [DATA_WIDTH-1:0]     read_data,
  output logic                      rd_valid
);

  localparam int BE_W  = be_w(DATA_WIDTH);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  if (DATA_WIDTH % 8 != 0) begin : g_bad_width
    $error("dp_ram_clr: DATA_WIDTH must be a multiple of 8");
  end
  if (DATA_WIDTH > MAX_DW) begin : g_too_wide
    $error("dp_ram_clr: DATA_WIDTH exceeds merge_bytes container");
  end

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [BE_W-1:0]       mem_be;
  logic [DATA_WIDTH-1:0] mem_merged;
  logic [DATA_WIDTH-1:0] rd_old;

  logic [DATA_WIDTH-1:0] read_data_q, read_data_d;
  logic                  rd_valid_q, rd_valid_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  dp_ram_clr_fsm #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .CLR_VALUE  (CLR_VALUE)
  ) u_fsm (
    .wr_clk     (wr_clk),
    .reset      (reset),
    .clr_req    (clr_req),
    .wr_en      (wr_en),
    .wr_be      (wr_be),
    .write_addr (write_addr),
    .write_data (write_data),
    .busy       (busy),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be)
  );

  // The clear engine drives mem_be all-ones, so the merge passes CLR_VALUE through.
  always_comb begin
    mem_merged = DATA_WIDTH'(merge_bytes(word_max_t'(mem[mem_addr]),
                                         word_max_t'(mem_wdata),
                                         be_max_t'(mem_be)));
  end

  // The array is deliberately outside the reset domain.
  always_ff @(posedge wr_clk) begin
    if (mem_we) mem[mem_addr] <= mem_merged;
  end

  always_comb begin
    rd_old      = mem[read_addr];
    read_data_d = read_data_q;
    rd_valid_d  = 1'b0;
    if (rd_en && !busy) begin
      rd_valid_d  = 1'b1;
      read_data_d = rd_old;
      // busy is low here, so a same-cycle wr_en is an accepted write.
      if (BYPASS != 0 && wr_en && write_addr == read_addr) begin
        read_data_d = DATA_WIDTH'(merge_bytes(word_max_t'(rd_old),
                                              word_max_t'(write_data),
                                              be_max_t'(wr_be)));
      end
    end
  end

  always_ff @(posedge wr_clk or posedge reset) begin
    if (reset) begin
      read_data_q <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      read_data_q <= read_data_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  assign read_data = read_data_q;
  assign rd_valid  = rd_valid_q;

endmodule

// File: tb/tb_dp_ram_clr.sv
// tb/tb_dp_ram_clr.sv - scoreboard bench for dp_ram_clr
module tb_dp_ram_clr;

  localparam int          DW        = 32;
  localparam int          AW        = 4;
  localparam int          DEPTH     = 16;
  localparam int          BYPASS    = 1;
  localparam logic [31:0] CLR_VALUE = 32'h0;

  logic        wr_clk;
  logic        reset;
  logic        clr_req;
  logic        busy;
  logic        wr_en;
  logic [3:0]  wr_be;
  logic [3:0]  write_addr;
  logic [31:0] write_data;
  logic        rd_en;
  logic [3:0]  read_addr;
  logic [31:0] read_data;
  logic        rd_valid;

  dp_ram_clr #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .BYPASS     (BYPASS),
    .CLR_VALUE  (CLR_VALUE)
  ) dut (
    .wr_clk     (wr_clk),
    .reset      (reset),
    .clr_req    (clr_req),
    .busy       (busy),
    .wr_en      (wr_en),
    .wr_be      (wr_be),
    .write_addr (write_addr),
    .write_data (write_data),
    .rd_en      (rd_en),
    .read_addr  (read_addr),
    .read_data  (read_data),
    .rd_valid   (rd_valid)
  );

  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  int edge_cnt = 0;
  always @(posedge wr_clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    logic [31:0] data;
    int          edge_no;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          errors = 0;
  int          checks = 0;

  // Reference model: word array plus count of remaining clear cycles.
  logic [31:0] model_mem [DEPTH];
  int          clr_left;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] byte_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = CLR_VALUE;
    clr_left = DEPTH;
  endtask

  // One clock edge of stimulus; called at posedge+1.
  task automatic step(input logic we, input logic [3:0] be, input logic [3:0] wa,
                      input logic [31:0] wd, input logic re, input logic [3:0] ra,
                      input logic cr);
    exp_t        e;
    logic [31:0] rdw;
    wr_en = we; wr_be = be; write_addr = wa; write_data = wd;
    rd_en = re; read_addr = ra; clr_req = cr;
    if (clr_left == 0) begin
      if (re) begin
        rdw = model_mem[ra];
        if (BYPASS != 0 && we && wa == ra) rdw = byte_merge(rdw, wd, be);
        e.data = rdw;
        e.edge_no = edge_cnt + 1;
        sb.push_back(e);
      end
      if (we) model_mem[wa] = byte_merge(model_mem[wa], wd, be);
      if (cr) model_clear();
    end else begin
      clr_left--;
    end
    @(posedge wr_clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; clr_req = 1'b0; wr_be = 4'h0;
    check("busy", {31'b0, busy}, {31'b0, (clr_left != 0)});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0, 1'b0);
  endtask

  task automatic do_reset(input int hold);
    reset = 1'b1;
    #1;
    sb.delete();
    check("reset_busy", {31'b0, busy}, 32'd1);
    check("reset_rd_valid", {31'b0, rd_valid}, 32'd0);
    check("reset_read_data", read_data, 32'h0);
    repeat (hold) @(posedge wr_clk);
    #1;
    check("reset_hold_busy", {31'b0, busy}, 32'd1);
    check("reset_hold_rd_valid", {31'b0, rd_valid}, 32'd0);
    reset = 1'b0;
    model_clear();
  endtask

  // Monitor: pops an expectation whenever the DUT presents rd_valid.
  initial begin
    forever begin
      @(negedge wr_clk);
      if (rd_valid === 1'b1) begin
        if (sb.size() == 0) begin
          check("rd_valid_unexpected", 32'd1, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check("read_data", read_data, mon_e.data);
          check("rd_latency", 32'(edge_cnt), 32'(mon_e.edge_no));
        end
      end
    end
  end

  initial begin
    reset = 1'b1; clr_req = 1'b0; wr_en = 1'b0; wr_be = 4'h0; write_addr = 4'h0;
    write_data = 32'h0; rd_en = 1'b0; read_addr = 4'h0;
    clr_left = DEPTH;
    @(posedge wr_clk);
    #1;
    do_reset(3);

    // Initial sweep, then every word reads back the clear value.
    idle(DEPTH);
    for (int a = 0; a < DEPTH; a++) step(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'(a), 1'b0);
    idle(2);

    // Full and partial byte-enable writes.
    step(1'b1, 4'hF, 4'd3, 32'hDEADBEEF, 1'b0, 4'd0, 1'b0);
    step(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd3, 1'b0);
    step(1'b1, 4'b0101, 4'd3, 32'h11223344, 1'b0, 4'd0, 1'b0);
    step(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd3, 1'b0);
    step(1'b1, 4'h0, 4'd3, 32'hCAFEF00D, 1'b0, 4'd0, 1'b0);
    step(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd3, 1'b0);

    // Same-address collision, then follow-up read.
    step(1'b1, 4'b0011, 4'd5, 32'hA5A5A5A5, 1'b1, 4'd5, 1'b0);
    step(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd5, 1'b0);
    // Different addresses in the same cycle.
    step(1'b1, 4'hF, 4'd6, 32'h01020304, 1'b1, 4'd3, 1'b0);
    step(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd6, 1'b0);
    idle(2);

    // Re-clear; requests during busy are ignored.
    step(1'b0, 4'h0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b1);
    step(1'b1, 4'hF, 4'd3, 32'hFFFFFFFF, 1'b1, 4'd3, 1'b0);
    step(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd5, 1'b1);
    idle(DEPTH - 2);
    step(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd3, 1'b0);
    step(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd5, 1'b0);
    idle(2);

    // Randomized traffic with frequent collisions and occasional clears.
    for (int i = 0; i < 400; i++) begin
      logic        we, re, cr;
      logic [3:0]  be, wa, ra;
      logic [31:0] wd;
      we = 1'($urandom_range(0, 1));
      re = 1'($urandom_range(0, 1));
      cr = ($urandom_range(0, 59) == 0);
      be = 4'($urandom_range(0, 15));
      wa = 4'($urandom_range(0, 15));
      ra = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15));
      wd = $urandom;
      step(we, be, wa, wd, re, ra, cr);
    end
    idle(DEPTH + 2);

    // Reset mid-sweep at clr_addr = 7 aborts and restarts the clear.
    for (int a = 0; a < DEPTH; a++) step(1'b1, 4'hF, 4'(a), $urandom, 1'b0, 4'd0, 1'b0);
    reset = 1'b1;
    #1;
    reset = 1'b0;
    model_clear();
    idle(7);
    do_reset(2);
    idle(DEPTH);
    for (int a = 0; a < DEPTH; a++) step(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'(a), 1'b0);

    // Reset with a read in flight drops rd_valid immediately.
    step(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd2, 1'b0);
    do_reset(1);
    idle(DEPTH + 2);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dp_ram_clr.md
Name: dp_ram_clr

Overview:
Parametrised simple dual-port, single-clock block RAM with registered (1-cycle) synchronous read, per-byte write enables, and a configurable read-during-write policy. The memory array is not reset directly. An internal clear engine walks every address and writes CLR_VALUE after reset or on request. Used as the scratch/weight store between the NLP cores, where large depths rule out resetting the whole array in one cycle.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
ADDR_WIDTH, 8, address width; DEPTH = 2**ADDR_WIDTH words.
BYPASS, 1, 1 = write-first on same-address collision, 0 = read-old.
CLR_VALUE, 0, word value written by the clear engine.

Ports:
wr_clk  in  1  single clock for all logic.
reset  in  1  asynchronous, active-high reset.
clr_req  in  1  one-cycle request to re-clear the whole array.
busy  out  1  high while the clear engine runs.
wr_en  in  1  write strobe.
wr_be  in  DATA_WIDTH/8  byte enables (bit i -> bits 8i+7:8i).
write_addr  in  ADDR_WIDTH  write address.
write_data  in  DATA_WIDTH  write data.
rd_en  in  1  read strobe.
read_addr  in  ADDR_WIDTH  read address.
read_data  out  DATA_WIDTH  registered read data.
rd_valid  out  1  one-cycle pulse qualifying read_data.

Behaviour:
- Clocking and reset: one clock, wr_clk. Reset is asynchronous and active-high on port reset.
- Reset values while reset is high: FSM = CLEAR, clr_addr = 0, busy = 1, read_data = 0, rd_valid = 0. The mem array is untouched by reset.
- FSM states:
  - CLEAR: each cycle mem[clr_addr] <= CLR_VALUE and clr_addr increments. When clr_addr == DEPTH-1 is written, next state is IDLE.
  - IDLE: normal operation. clr_req = 1 moves to CLEAR with clr_addr = 0 on the next edge.
- busy is a registered copy of (state == CLEAR). It is high for exactly DEPTH cycles after reset release or after the clr_req edge.
- Requests during busy: wr_en, rd_en and clr_req are ignored. No queueing, no restart. rd_valid stays 0.
- Write (IDLE, wr_en = 1): each byte i with wr_be[i] = 1 is updated. wr_be = 0 is a no-op.
- Read (IDLE, rd_en = 1 at edge N): read_data is updated at edge N and rd_valid = 1 for the cycle after edge N only. Latency is 1 cycle.
- read_data holds its last value whenever no read is accepted, including during CLEAR.
- Collision (same cycle, same address, both accepted):
  - BYPASS = 1: read_data = old word with enabled bytes replaced by write_data.
  - BYPASS = 0: read_data = old word.
- Different-address reads and writes in the same cycle are independent.
- Addresses are full-range because DEPTH is a power of 2. clr_addr is ADDR_WIDTH wide and wraps naturally.
- Reset asserted mid-clear aborts the sweep. The clear restarts from address 0 after release and takes a full DEPTH cycles.
- Reset asserted in IDLE with a read in flight: rd_valid is forced to 0 immediately (asynchronous).
- Elaboration check: assert DATA_WIDTH % 8 == 0.

Decomposition:
- Package dp_ram_pkg holds:
  - typedef enum logic {CLEAR, IDLE} clr_state_t;
  - localparam function for BE_W = DATA_WIDTH/8;
  - function merge_bytes(old, new, be), shared by the write path and the bypass path.
- Sub-module dp_ram_clr_fsm is natural: it holds the state, clr_addr, busy, and the clear write-port mux.
- The top holds the array, byte-merge logic and read register.

Test Plan:
All scenarios use DATA_WIDTH = 32, ADDR_WIDTH = 4 (DEPTH = 16).
1. Release reset -> busy = 1 for exactly 16 cycles, then 0. Reading addresses 0..15 -> read_data = 0x00000000 each, with one rd_valid pulse per read.
2. Write addr 3 = 0xDEADBEEF (wr_be = 4'hF), then rd_en at addr 3 -> read_data = 0xDEADBEEF and rd_valid high exactly one cycle after the read edge.
3. Then write addr 3 = 0x11223344 with wr_be = 4'b0101, then read addr 3 -> 0xDE22BE44.
4. Same-cycle write addr 5 = 0xA5A5A5A5 (wr_be = 4'b0011) and read addr 5 after clear -> BYPASS = 1: 0x0000A5A5; BYPASS = 0: 0x00000000. A follow-up read -> 0x0000A5A5 in both cases.
5. clr_req pulse in IDLE -> busy high 16 cycles. A write to addr 3 = 0xFFFFFFFF and a read during busy are ignored (rd_valid stays 0). Afterwards addr 3 reads 0x00000000.
6. Assert reset when clr_addr = 7 -> busy stays 1 and rd_valid = 0. After release, busy is high for 16 more cycles and all words read 0.
